// File: rtl/shift_deser.sv
// shift_deser: serial-to-parallel receiver with a one-entry valid/ready
// output buffer. Words are assembled MSB-first or LSB-first with optional
// bit inversion; the direction is latched on the first bit of every word.
// A completed word arriving while the buffer is still full is dropped and
// reported with a single-cycle overrun pulse.

module shift_deser #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sin_i,
    input  logic [1:0]       dir_i,
    input  logic             sync_i,
    output logic [WIDTH-1:0] out_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CW-1:0]    cnt_o,
    output logic             overrun_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [1:0]       dir_l_q,     dir_l_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q,   overrun_d;

    logic             first_s;
    logic [1:0]       dir_eff_s;
    logic             bit_s;
    logic [WIDTH-1:0] sr_shift_s;
    logic             complete_s;
    logic             consume_s;

    // Bit conditioning, shift value and word-completion/handshake decode.
    always_comb begin
        first_s    = sync_i | (cnt_q == {CW{1'b0}});
        dir_eff_s  = first_s ? dir_i : dir_l_q;
        bit_s      = sin_i ^ dir_eff_s[1];
        if (dir_eff_s[0]) begin
            sr_shift_s = {bit_s, sr_q[WIDTH-1:1]};
        end else begin
            sr_shift_s = {sr_q[WIDTH-2:0], bit_s};
        end
        // sync restarts the frame, so it always suppresses completion
        complete_s = en_i & ~sync_i & (cnt_q == CNT_LAST);
        consume_s  = out_valid_q & out_ready_i;
    end

    // Next-state for the shift register, bit counter and latched direction.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dir_l_d = dir_l_q;
        if (sync_i) begin
            if (en_i) begin
                sr_d    = sr_shift_s;
                cnt_d   = CW'(1);
                dir_l_d = dir_i;
            end else begin
                cnt_d   = {CW{1'b0}};
            end
        end else if (en_i) begin
            sr_d = sr_shift_s;
            if (complete_s) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            if (first_s) begin
                dir_l_d = dir_i;
            end else begin
                dir_l_d = dir_l_q;
            end
        end else begin
            sr_d    = sr_q;
            cnt_d   = cnt_q;
            dir_l_d = dir_l_q;
        end
    end

    // Next-state for the output buffer, valid flag and overrun pulse.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (complete_s) begin
            if (!out_valid_q || out_ready_i) begin
                out_d       = sr_shift_s;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q        <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            dir_l_q     <= 2'b00;
            out_q       <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            dir_l_q     <= dir_l_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign cnt_o       = cnt_q;
    assign overrun_o   = overrun_q;

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel receive block that converts the single-bit stream driven out of the shift register into WIDTH-bit words. It reassembles the stream MSB-first or LSB-first, with optional bit inversion, under the same `en`/`dir` control style as the shift register. Completed words go to a one-entry output buffer with a valid/ready handshake, so downstream logic can apply backpressure. Overflow of that buffer is flagged.

## Interface
- WIDTH, 8, word length in bits (≥2)
- CW, $clog2(WIDTH), bit-counter width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- en  in  1  sample `sin` on this edge when high; no bit is taken when low
- sin  in  1  serial data bit
- dir  in  2  dir[0]: 0 = MSB-first, 1 = LSB-first; dir[1]: 1 = invert each received bit
- sync  in  1  frame restart: discard the partial word; the bit sampled this edge (if en) is bit 0 of a new word
- out  out  WIDTH  buffered word
- out_valid  out  1  `out` holds an unconsumed word
- out_ready  in  1  consumer accepts `out` on an edge where out_valid & out_ready
- cnt  out  CW  bits collected in the current partial word
- overrun  out  1  one-cycle pulse: a completed word was dropped

## Operation
- Datapath: shift register `sr`, bit counter `cnt`, latched direction `dir_l`, output register `out`, and the `out_valid` flag.
- Bit value b = sin ^ dir[1] for the first bit of a word, and sin ^ dir_l[1] for later bits.
- `dir_l` is captured on the edge that takes the first bit of a word (cnt==0, or sync). Changes to `dir` in the middle of a word are ignored until the next word.
- MSB-first: sr <= {sr[WIDTH-2:0], b}. LSB-first: sr <= {b, sr[WIDTH-1:1]}.
- Each accepted bit (en=1) increments cnt. When cnt==WIDTH-1 and a bit is accepted, the word completes: the final value includes b, and cnt wraps to 0.
- Completion with the buffer free (out_valid=0, or out_ready=1 this edge): load `out`; out_valid=1.
- Completion with out_valid=1 and out_ready=0: word dropped, `out` unchanged, overrun=1 for one cycle, cnt still wraps to 0.
- Consume without completion: out_valid clears.
- sync=1 and en=0: cnt <= 0, sr content don't-care, no word emitted.
- sync=1 and en=1: cnt <= 1, dir_l <= dir, and the bit is stored as the first bit. A partial word is never emitted.
- Simultaneous sync with cnt==WIDTH-1: sync wins and the word does not complete.
- en=0: sr, cnt and dir_l hold. The handshake still operates.

## Timing
- Reset values: out=0, out_valid=0, cnt=0, overrun=0, sr=0, dir_l=0.
- rst overrides everything on its edge. Asserting it mid-word or while out_valid=1 discards the partial word and the buffered word.
- Latency: when the last bit is sampled at edge k, out and out_valid are valid immediately after edge k (0 extra cycles).
- Throughput: one word every WIDTH enabled cycles, sustained with out_ready=1.
- out_valid=1 is required to stay high and `out` stable until consumed.
- overrun is high only in the cycle after the dropping edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, dir=00, en=1, out_ready=1, stream 1,0,1,0,0,1,0,1 -> after the 8th edge, out=0xA5, out_valid=1, cnt=0; out_valid drops one cycle later.
- dir=01, stream 0,0,0,0,0,0,0,1 -> out=0x80. Repeat with dir=00 -> out=0x01. Then dir=10 with the 0xA5 stream -> out=0x5A.
- en toggled low every other cycle while sending 0x3C MSB-first -> out=0x3C after 8 enabled bits; cnt holds during en=0 gaps.
- out_ready=0, send 0x11 then 0x22 -> out=0x11 held, overrun pulses for exactly 1 cycle at the completion of the 2nd word. Then out_ready=1 -> out_valid clears. Send 0x33 -> out=0x33.
- Send 5 bits, assert sync with en=1 and sin=1, then 7 more bits of 0xC3's tail (1,0,0,0,0,1,1) -> out=0xC3 and no partial word emitted. Switching dir to 01 at bit 4 of a word has no effect on that word.
- Assert rst after 4 bits with out_valid=1 -> all outputs 0 the next cycle. A fresh 0xF0 stream -> out=0xF0.
